// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage with N-source forwarding, load-use interlock and valid/ready handshakes
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid_i,
    input  logic [XLEN-1:0]           if_pc_i,
    input  logic [31:0]               if_inst_i,
    input  logic                      if_pred_jump_i,
    output logic                      id_ready_o,
    input  logic                      flush_i,
    output logic [4:0]                reg1_addr_o,
    output logic [4:0]                reg2_addr_o,
    input  logic [XLEN-1:0]           reg1_data_i,
    input  logic [XLEN-1:0]           reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
    input  logic [XLEN*NUM_FWD-1:0]   fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_pend_i,
    output logic                      ex_valid_o,
    input  logic                      ex_ready_i,
    output logic [XLEN-1:0]           ex_pc_o,
    output logic [2:0]                ex_aluop_o,
    output logic [4:0]                ex_alusel_o,
    output logic [XLEN-1:0]           ex_imm_o,
    output logic [XLEN-1:0]           ex_reg1_o,
    output logic [XLEN-1:0]           ex_reg2_o,
    output logic                      ex_wreg_o,
    output logic [4:0]                ex_wd_o,
    output logic                      ex_jump_o,
    output logic                      ex_is_load_o,
    output logic                      illegal_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // aluop is the instruction class; alusel selects the operation within it
    localparam logic [2:0] ALU_NOP    = 3'd0;
    localparam logic [2:0] ALU_ARITH  = 3'd1;
    localparam logic [2:0] ALU_LUI    = 3'd2;
    localparam logic [2:0] ALU_AUIPC  = 3'd3;
    localparam logic [2:0] ALU_JUMP   = 3'd4;
    localparam logic [2:0] ALU_BRANCH = 3'd5;
    localparam logic [2:0] ALU_LOAD   = 3'd6;
    localparam logic [2:0] ALU_STORE  = 3'd7;

    typedef enum logic {RUN, HAZ} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      aluop;
        logic [4:0]      alusel;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] reg1;
        logic [XLEN-1:0] reg2;
        logic            wreg;
        logic [4:0]      wd;
        logic            jump;
    } payload_t;

    payload_t         dec, pay_d, pay_q;
    state_t           state_d, state_q;
    logic             valid_d, valid_q;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic        r1_rd, r2_rd, unknown;
    logic        pend1, pend2, hazard, adv, accept;

    assign opcode = if_inst_i[6:0];
    assign f3     = if_inst_i[14:12];
    assign rd     = if_inst_i[11:7];
    assign rs1    = if_inst_i[19:15];
    assign rs2    = if_inst_i[24:20];
    assign imm_i  = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
    assign imm_s  = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
    assign imm_b  = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7], if_inst_i[30:25], if_inst_i[11:8], 1'b0};
    assign imm_u  = {if_inst_i[31:12], 12'b0};
    assign imm_j  = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12], if_inst_i[20], if_inst_i[30:21], 1'b0};

    // Opcode decode: class, sub-op, immediate form and which registers are read
    always_comb begin
        dec.aluop  = ALU_NOP;
        dec.alusel = 5'd0;
        imm32      = 32'd0;
        r1_rd      = 1'b0;
        r2_rd      = 1'b0;
        dec.wreg   = 1'b0;
        unknown    = 1'b0;
        case (opcode)
            OPC_OP:     begin dec.aluop = ALU_ARITH; dec.alusel = {1'b0, if_inst_i[30], f3}; r1_rd = 1'b1; r2_rd = 1'b1; dec.wreg = 1'b1; end
            OPC_OPIMM:  begin dec.aluop = ALU_ARITH; dec.alusel = {1'b0, (f3 == 3'b101) & if_inst_i[30], f3}; imm32 = imm_i; r1_rd = 1'b1; dec.wreg = 1'b1; end
            OPC_LOAD:   begin dec.aluop = ALU_LOAD; dec.alusel = {2'b0, f3}; imm32 = imm_i; r1_rd = 1'b1; dec.wreg = 1'b1; end
            OPC_STORE:  begin dec.aluop = ALU_STORE; dec.alusel = {2'b0, f3}; imm32 = imm_s; r1_rd = 1'b1; r2_rd = 1'b1; end
            OPC_BRANCH: begin dec.aluop = ALU_BRANCH; dec.alusel = {2'b0, f3}; imm32 = imm_b; r1_rd = 1'b1; r2_rd = 1'b1; end
            OPC_LUI:    begin dec.aluop = ALU_LUI; imm32 = imm_u; dec.wreg = 1'b1; end
            OPC_AUIPC:  begin dec.aluop = ALU_AUIPC; imm32 = imm_u; dec.wreg = 1'b1; end
            OPC_JAL:    begin dec.aluop = ALU_JUMP; imm32 = imm_j; dec.wreg = 1'b1; end
            OPC_JALR:   begin dec.aluop = ALU_JUMP; dec.alusel = 5'd1; imm32 = imm_i; r1_rd = 1'b1; dec.wreg = 1'b1; end
            default:    unknown = 1'b1;
        endcase
        dec.imm  = XLEN'($signed(imm32));
        dec.wd   = dec.wreg ? rd : 5'd0;
        dec.pc   = if_pc_i;
        dec.jump = if_pred_jump_i;
    end

    assign reg1_addr_o = r1_rd ? rs1 : 5'd0;
    assign reg2_addr_o = r2_rd ? rs2 : 5'd0;

    // Operand resolution: scan channels oldest-first so the youngest match overwrites; x0 never forwards
    always_comb begin
        dec.reg1 = '0;
        dec.reg2 = '0;
        pend1    = 1'b0;
        pend2    = 1'b0;
        if (r1_rd && rs1 != 5'd0) begin
            dec.reg1 = reg1_data_i;
            for (int k = NUM_FWD - 1; k >= 0; k--)
                if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == rs1) begin
                    dec.reg1 = fwd_wdata_i[XLEN*k +: XLEN];
                    pend1    = fwd_pend_i[k];
                end
        end
        if (r2_rd && rs2 != 5'd0) begin
            dec.reg2 = reg2_data_i;
            for (int k = NUM_FWD - 1; k >= 0; k--)
                if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == rs2) begin
                    dec.reg2 = fwd_wdata_i[XLEN*k +: XLEN];
                    pend2    = fwd_pend_i[k];
                end
        end
    end

    assign hazard     = pend1 | pend2;
    assign adv        = ~valid_q | ex_ready_i;
    assign accept     = adv & if_valid_i & ~hazard & ~flush_i;
    assign id_ready_o = flush_i | (adv & ~hazard);

    // Next state: output register, illegal pulse, interlock FSM and saturating stall counter
    always_comb begin
        pay_d     = accept ? dec : pay_q;
        valid_d   = flush_i ? 1'b0 : (adv ? (if_valid_i & ~hazard) : valid_q);
        illegal_d = accept & unknown;
        state_d   = (state_q == RUN) ? ((if_valid_i & hazard & adv & ~flush_i) ? HAZ : RUN)
                                     : ((~hazard | flush_i) ? RUN : HAZ);
        cnt_d     = (state_q == HAZ && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    // State registers; reset drops any held instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            state_q   <= RUN;
            cnt_q     <= '0;
        end else begin
            pay_q     <= pay_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid_o   = valid_q;
    assign ex_pc_o      = pay_q.pc;
    assign ex_aluop_o   = pay_q.aluop;
    assign ex_alusel_o  = pay_q.alusel;
    assign ex_imm_o     = pay_q.imm;
    assign ex_reg1_o    = pay_q.reg1;
    assign ex_reg2_o    = pay_q.reg2;
    assign ex_wreg_o    = pay_q.wreg;
    assign ex_wd_o      = pay_q.wd;
    assign ex_jump_o    = pay_q.jump;
    assign ex_is_load_o = pay_q.aluop == ALU_LOAD;
    assign illegal_o    = illegal_q;
    assign stall_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of decode, forwarding, interlock, backpressure, flush and reset
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_i, if_pred_jump_i, flush_i, ex_ready_i;
    logic [31:0] if_pc_i, if_inst_i;
    logic        id_ready_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i, fwd_pend_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic        ex_valid_o, ex_wreg_o, ex_jump_o, ex_is_load_o, illegal_o;
    logic [31:0] ex_pc_o, ex_imm_o, ex_reg1_o, ex_reg2_o;
    logic [2:0]  ex_aluop_o;
    logic [4:0]  ex_alusel_o, ex_wd_o;
    logic [15:0] stall_cnt_o;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign reg1_data_i = 32'h1000 + {27'd0, reg1_addr_o};
    assign reg2_data_i = 32'h2000 + {27'd0, reg2_addr_o};

    id_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .if_pred_jump_i(if_pred_jump_i),
        .id_ready_o(id_ready_o), .flush_i(flush_i),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
        .ex_alusel_o(ex_alusel_o), .ex_imm_o(ex_imm_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
        .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_jump_o(ex_jump_o), .ex_is_load_o(ex_is_load_o),
        .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int k, input logic w, input logic [4:0] wd, input logic [31:0] d, input logic p);
        fwd_wreg_i[k]          = w;
        fwd_wd_i[5*k +: 5]     = wd;
        fwd_wdata_i[32*k +: 32] = d;
        fwd_pend_i[k]          = p;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        if_inst_i  = inst;
    endtask

    initial begin
        rst_n = 1'b0; if_valid_i = 1'b0; if_pc_i = '0; if_inst_i = '0; if_pred_jump_i = 1'b0;
        flush_i = 1'b0; ex_ready_i = 1'b1;
        fwd_wreg_i = '0; fwd_pend_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
        #12;
        check("rst_valid", ex_valid_o, 0);
        check("rst_cnt", stall_cnt_o, 0);
        check("rst_illegal", illegal_o, 0);
        check("rst_pc", ex_pc_o, 0);
        rst_n = 1'b1;
        // addi x1,x0,5 then add x2,x1,x1: channel 0 beats channel 1
        set_fwd(0, 1, 5'd1, 32'd7, 0);
        set_fwd(1, 1, 5'd1, 32'd9, 0);
        present(32'h100, 32'h00500093);
        #1 check("t1_ready", id_ready_o, 1);
        tick;
        check("t1_valid", ex_valid_o, 1);
        check("t1_imm", ex_imm_o, 5);
        check("t1_reg1_x0", ex_reg1_o, 0);
        check("t1_wd", ex_wd_o, 1);
        check("t1_pc", ex_pc_o, 32'h100);
        present(32'h104, 32'h00108133);
        tick;
        check("t1_fwd_reg1", ex_reg1_o, 7);
        check("t1_fwd_reg2", ex_reg2_o, 7);
        check("t1_wd2", ex_wd_o, 2);
        // add x3,x0,x0 with a channel targeting x0
        set_fwd(0, 1, 5'd0, 32'hFFFF, 0);
        set_fwd(1, 0, 5'd0, 32'd0, 0);
        present(32'h108, 32'h000001B3);
        tick;
        check("t2_reg1", ex_reg1_o, 0);
        check("t2_reg2", ex_reg2_o, 0);
        // beq x1,x2,-8 from the regfile
        set_fwd(0, 0, 5'd0, 32'd0, 0);
        present(32'h10C, 32'hFE208CE3);
        tick;
        check("beq_reg1", ex_reg1_o, 32'h1001);
        check("beq_reg2", ex_reg2_o, 32'h2002);
        check("beq_imm", ex_imm_o, 32'hFFFFFFF8);
        check("beq_wreg", ex_wreg_o, 0);
        check("beq_aluop", ex_aluop_o, 5);
        // load-use on x5 for two cycles
        set_fwd(0, 1, 5'd5, 32'h55, 1);
        present(32'h110, 32'h00128333);
        #1 check("t3_ready0", id_ready_o, 0);
        tick;
        check("t3_bubble1", ex_valid_o, 0);
        check("t3_ready1", id_ready_o, 0);
        tick;
        check("t3_bubble2", ex_valid_o, 0);
        check("t3_cnt1", stall_cnt_o, 1);
        fwd_pend_i[0] = 1'b0;
        #1 check("t3_ready2", id_ready_o, 1);
        tick;
        check("t3_valid", ex_valid_o, 1);
        check("t3_reg1", ex_reg1_o, 32'h55);
        check("t3_reg2", ex_reg2_o, 32'h2001);
        check("t3_cnt2", stall_cnt_o, 2);
        check("t3_pc", ex_pc_o, 32'h110);
        // lw x7,8(x2) back-to-back
        set_fwd(0, 0, 5'd0, 32'd0, 0);
        present(32'h114, 32'h00812383);
        tick;
        check("lw_is_load", ex_is_load_o, 1);
        check("lw_imm", ex_imm_o, 8);
        check("lw_reg1", ex_reg1_o, 32'h1002);
        check("lw_wd", ex_wd_o, 7);
        check("lw_aluop", ex_aluop_o, 6);
        // backpressure for 3 cycles
        ex_ready_i = 1'b0;
        present(32'h118, 32'h00500093);
        #1 check("t4_ready0", id_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t4_hold_valid", ex_valid_o, 1);
            check("t4_hold_imm", ex_imm_o, 8);
            check("t4_hold_pc", ex_pc_o, 32'h114);
        end
        ex_ready_i = 1'b1;
        #1 check("t4_ready1", id_ready_o, 1);
        tick;
        check("t4_pc", ex_pc_o, 32'h118);
        check("t4_imm", ex_imm_o, 5);
        check("t4_valid", ex_valid_o, 1);
        check("t4_not_load", ex_is_load_o, 0);
        // flush during a hazard stall
        set_fwd(0, 1, 5'd5, 32'h55, 1);
        present(32'h11C, 32'h00128333);
        tick;
        check("t5_bubble", ex_valid_o, 0);
        check("t5_cnt2", stall_cnt_o, 2);
        tick;
        check("t5_cnt3", stall_cnt_o, 3);
        flush_i = 1'b1;
        #1 check("t5_ready", id_ready_o, 1);
        tick;
        check("t5_valid", ex_valid_o, 0);
        check("t5_cnt4", stall_cnt_o, 4);
        flush_i = 1'b0;
        if_valid_i = 1'b0;
        tick;
        tick;
        check("t5_cnt_stop", stall_cnt_o, 4);
        set_fwd(0, 0, 5'd0, 32'd0, 0);
        // illegal opcode
        present(32'h120, 32'h0000007F);
        tick;
        check("t6_illegal", illegal_o, 1);
        check("t6_wreg", ex_wreg_o, 0);
        check("t6_valid", ex_valid_o, 1);
        check("t6_aluop", ex_aluop_o, 0);
        if_valid_i = 1'b0;
        tick;
        check("t6_pulse_end", illegal_o, 0);
        check("t6_idle", ex_valid_o, 0);
        // lui x9,0x12345 then asynchronous reset mid-cycle
        present(32'h124, 32'h123454B7);
        tick;
        check("lui_imm", ex_imm_o, 32'h12345000);
        check("lui_wd", ex_wd_o, 9);
        check("lui_valid", ex_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", ex_valid_o, 0);
        check("arst_imm", ex_imm_o, 0);
        check("arst_pc", ex_pc_o, 0);
        check("arst_cnt", stall_cnt_o, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
